// File: rtl/qea_host_sequencer.sv
// Host-side run sequencer for the QEA accelerator: loads gate context, writes the |0..0> state,
// starts the run, waits for complete and streams the state vector out under valid/ready.
//
// state    | meaning
// IDLE     | waiting for an acceptable go request
// LOAD_CTX | accepting context words into CTX RAM, addr 0..ins_num-1
// INIT_ST  | writing |0..0> into STATE RAM, addr 0..W-1
// START    | single-cycle start to QEA
// WAIT     | waiting for QEA complete
// READ     | reading STATE RAM 0..W-1 through the readout FIFO
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_out_data,
  output logic                                 o_out_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic                                 o_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout
);

  localparam int WORD_W     = PE_NUM * STATE_DATA_WIDTH;
  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SA_W       = STATE_ADDR_WIDTH;
  localparam int CA_W       = GATE_CONTEXT_ADDR_WIDTH;

  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [CA_W:0]             INS_MAX  = {1'b1, {CA_W{1'b0}}};
  localparam logic [DATA_WIDTH-1:0]     ONE_FX   = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << NUM_FRAC_BIT;
  // 1.0 real sits in the top slice; its imaginary half and every other amplitude are zero
  localparam logic [WORD_W-1:0]         WORD0    = {ONE_FX, {(WORD_W-DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_INIT_ST, S_START, S_WAIT, S_READ
  } state_t;

  state_t state_q, state_d;

  logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
  logic [CA_W-1:0]           ins_last_q, ins_last_d;
  logic [SA_W-1:0]           last_word_q, last_word_d;
  logic [CA_W-1:0]           ctx_cnt_q, ctx_cnt_d;
  logic [SA_W-1:0]           init_cnt_q, init_cnt_d;
  logic [SA_W-1:0]           rd_addr_q, rd_addr_d;
  logic                      rd_all_q, rd_all_d;
  logic [SA_W-1:0]           out_cnt_q, out_cnt_d;

  logic                      ctx_en_q, ctx_en_d, ctx_wea_q, ctx_wea_d;
  logic [CA_W-1:0]           ctx_addr_q, ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic                      st_ena_q, st_ena_d, st_wea_q, st_wea_d;
  logic [SA_W-1:0]           st_addr_q, st_addr_d;
  logic [WORD_W-1:0]         st_din_q, st_din_d;
  logic                      done_q, done_d, err_q, err_d;

  logic [RD_LAT-1:0]         rd_pipe_q, rd_pipe_d;
  logic [CNT_W-1:0]          in_flight_q, in_flight_d;
  logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]          fifo_free;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]         fifo_q [FIFO_DEPTH];

  logic [SA_W:0]             words_full;
  logic                      go_ok, go_accept, ctx_accept, rd_issue, capture, out_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign go_ok = (i_qbit_num > QBIT_MIN) && (i_qbit_num <= QBIT_MAX) &&
                 (i_ins_num != '0) && (i_ins_num <= INS_MAX);
  assign words_full = (SA_W+1)'(1) << (i_qbit_num - QBIT_MIN);
  assign go_accept  = (state_q == S_IDLE) && i_go && go_ok;
  assign ctx_accept = (state_q == S_LOAD_CTX) && i_ctx_valid;

  // Only issue a read when a FIFO slot is guaranteed for it, counting reads still in the RAM pipe
  assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_cnt_q;
  assign rd_issue  = (state_q == S_READ) && !rd_all_q && (fifo_free > in_flight_q);
  assign capture   = rd_pipe_q[RD_LAT-1];
  assign out_fire  = o_out_valid && i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (go_accept) state_d = S_LOAD_CTX;
      S_LOAD_CTX: if (ctx_accept && (ctx_cnt_q == ins_last_q)) state_d = S_INIT_ST;
      S_INIT_ST:  if (init_cnt_q == last_word_q) state_d = S_START;
      S_START:    state_d = S_WAIT;
      S_WAIT:     if (i_complete) state_d = S_READ;
      S_READ:     if (out_fire && (out_cnt_q == last_word_q)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctx_en_d   = 1'b0;
    ctx_wea_d  = 1'b0;
    ctx_addr_d = '0;
    ctx_data_d = '0;
    st_ena_d   = 1'b0;
    st_wea_d   = 1'b0;
    st_addr_d  = '0;
    st_din_d   = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: err_d = i_go && !go_ok;
      S_LOAD_CTX: begin
        if (ctx_accept) begin
          ctx_en_d   = 1'b1;
          ctx_wea_d  = 1'b1;
          ctx_addr_d = ctx_cnt_q;
          ctx_data_d = i_ctx_data;
        end
      end
      S_INIT_ST: begin
        st_ena_d  = 1'b1;
        st_wea_d  = 1'b1;
        st_addr_d = init_cnt_q;
        st_din_d  = (init_cnt_q == '0) ? WORD0 : '0;
      end
      S_READ: begin
        if (rd_issue) begin
          st_ena_d  = 1'b1;
          st_addr_d = rd_addr_q;
        end
        done_d = out_fire && (out_cnt_q == last_word_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    qbit_d      = qbit_q;
    ins_last_d  = ins_last_q;
    last_word_d = last_word_q;
    ctx_cnt_d   = ctx_cnt_q;
    init_cnt_d  = init_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_all_d    = rd_all_q;
    out_cnt_d   = out_cnt_q;
    if (go_accept) begin
      qbit_d      = i_qbit_num;
      ins_last_d  = CA_W'(i_ins_num - (CA_W+1)'(1));
      last_word_d = SA_W'(words_full - (SA_W+1)'(1));
      ctx_cnt_d   = '0;
      init_cnt_d  = '0;
      rd_addr_d   = '0;
      rd_all_d    = 1'b0;
      out_cnt_d   = '0;
    end
    if (ctx_accept) ctx_cnt_d = ctx_cnt_q + 1'b1;
    if (state_q == S_INIT_ST) init_cnt_d = init_cnt_q + 1'b1;
    if (rd_issue) begin
      rd_addr_d = rd_addr_q + 1'b1;
      if (rd_addr_q == last_word_q) rd_all_d = 1'b1;
    end
    if (out_fire) out_cnt_d = out_cnt_q + 1'b1;
  end

  always_comb begin
    rd_pipe_d   = (rd_pipe_q << 1) | RD_LAT'(st_ena_q & ~st_wea_q);
    in_flight_d = in_flight_q + CNT_W'(rd_issue) - CNT_W'(capture);
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(capture) - CNT_W'(out_fire);
    wr_ptr_d    = capture  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = out_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qbit_q      <= '0;
      ins_last_q  <= '0;
      last_word_q <= '0;
      ctx_cnt_q   <= '0;
      init_cnt_q  <= '0;
      rd_addr_q   <= '0;
      rd_all_q    <= 1'b0;
      out_cnt_q   <= '0;
      ctx_en_q    <= 1'b0;
      ctx_wea_q   <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      st_ena_q    <= 1'b0;
      st_wea_q    <= 1'b0;
      st_addr_q   <= '0;
      st_din_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_pipe_q   <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      qbit_q      <= qbit_d;
      ins_last_q  <= ins_last_d;
      last_word_q <= last_word_d;
      ctx_cnt_q   <= ctx_cnt_d;
      init_cnt_q  <= init_cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_all_q    <= rd_all_d;
      out_cnt_q   <= out_cnt_d;
      ctx_en_q    <= ctx_en_d;
      ctx_wea_q   <= ctx_wea_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_data_q  <= ctx_data_d;
      st_ena_q    <= st_ena_d;
      st_wea_q    <= st_wea_d;
      st_addr_q   <= st_addr_d;
      st_din_q    <= st_din_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_pipe_q   <= rd_pipe_d;
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (capture) begin
      fifo_q[wr_ptr_q] <= i_state_dout;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_ctx_ready   = (state_q == S_LOAD_CTX);
  assign o_start       = (state_q == S_START);
  assign o_qbit_num    = qbit_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_wea_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = st_ena_q;
  assign o_state_wea   = st_wea_q;
  assign o_state_addra = st_addr_q;
  assign o_state_dina  = st_din_q;
  assign o_out_valid   = (fifo_cnt_q != '0);
  assign o_out_data    = fifo_q[rd_ptr_q];
  assign o_out_last    = o_out_valid && (out_cnt_q == last_word_q);

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Scoreboard bench for qea_host_sequencer: CTX/STATE write streams and state readout are checked
// against expectations queued when stimulus is driven; STATE RAM modelled with RD_LAT=3.
module tb_qea_host_sequencer;
  localparam int RD_LAT = 3;
  localparam int WW     = 256;
  localparam logic [WW-1:0] WORD0 = {32'h40000000, 224'h0};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_go;
  logic [5:0]      i_qbit_num;
  logic [16:0]     i_ins_num;
  logic            i_ctx_valid;
  logic            o_ctx_ready;
  logic [63:0]     i_ctx_data;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [WW-1:0]   o_out_data;
  logic            o_out_last;
  logic            o_busy, o_done, o_err, o_start;
  logic [5:0]      o_qbit_num;
  logic            o_ctx_en, o_ctx_wea;
  logic [15:0]     o_ctx_addr;
  logic [63:0]     o_ctx_data;
  logic            o_state_ena, o_state_wea;
  logic [15:0]     o_state_addra;
  logic [WW-1:0]   o_state_dina;
  logic            i_complete;
  logic [WW-1:0]   i_state_dout;

  always #5 clk = ~clk;

  qea_host_sequencer #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_last(o_out_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_start(o_start), .o_qbit_num(o_qbit_num), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
    .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
    .o_state_wea(o_state_wea), .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_complete(i_complete), .i_state_dout(i_state_dout)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [15:0]   addr;
    logic [WW-1:0] data;
  } wr_t;

  wr_t           ctx_q[$];
  wr_t           init_q[$];
  logic [WW-1:0] exp_q[$];

  // STATE RAM read side; contents are set by the bench when it plays the QEA run
  logic [WW-1:0] ram [1024];
  logic [WW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (o_state_ena && !o_state_wea) ? ram[o_state_addra[9:0]] : {8{32'hdeadbeef}};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_state_dout = rd_pipe[RD_LAT-1];

  int st_wr_cnt  = 0;
  int ctx_wr_cnt = 0;
  int start_cnt  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ctx_en) begin
        wr_t e;
        ctx_wr_cnt++;
        chk("ctx_write_expected", ctx_q.size() != 0, 1);
        if (ctx_q.size() != 0) begin
          e = ctx_q.pop_front();
          chk("ctx_addr", o_ctx_addr, e.addr);
          chk("ctx_data", o_ctx_data, e.data);
          chk("ctx_wea", o_ctx_wea, 1);
        end
      end
      if (o_state_ena && o_state_wea) begin
        wr_t e;
        st_wr_cnt++;
        chk("init_write_expected", init_q.size() != 0, 1);
        if (init_q.size() != 0) begin
          e = init_q.pop_front();
          chk("init_addr", o_state_addra, e.addr);
          chk("init_data", o_state_dina, e.data);
        end
      end
      if (o_start) start_cnt++;
    end
  end

  task automatic reject(input string tag, input int qbit, input int ins);
    int st0, c0;
    st0 = st_wr_cnt;
    c0  = ctx_wr_cnt;
    i_go = 1'b1;
    i_qbit_num = 6'(qbit);
    i_ins_num  = 17'(ins);
    @(negedge clk);
    i_go = 1'b0;
    chk(tag, o_err, 1);
    chk("reject_busy", o_busy, 0);
    @(negedge clk);
    chk("reject_err_one_cycle", o_err, 0);
    repeat (3) @(negedge clk);
    chk("reject_busy_later", o_busy, 0);
    chk("reject_no_writes", (st_wr_cnt - st0) + (ctx_wr_cnt - c0), 0);
  endtask

  task automatic run(input int qbit, input int ins, input bit gaps, input bit rnd_rdy,
                     input int abort_at);
    int w, k, cyc, beats, st0, start0;
    bit seen, hold;
    logic [WW-1:0] hold_data, e;
    wr_t ent;
    w = 1 << (qbit - 2);
    st0 = st_wr_cnt;
    start0 = start_cnt;
    for (int i = 0; i < w; i++) begin
      ent.addr = 16'(i);
      ent.data = (i == 0) ? WORD0 : '0;
      init_q.push_back(ent);
    end
    i_go = 1'b1;
    i_qbit_num = 6'(qbit);
    i_ins_num  = 17'(ins);
    @(negedge clk);
    i_go = 1'b0;
    chk("go_busy", o_busy, 1);
    chk("go_no_err", o_err, 0);
    chk("qbit_latched", o_qbit_num, 6'(qbit));

    k = 0;
    cyc = 0;
    while (k < ins && cyc < 4 * ins + 20) begin
      i_ctx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_ctx_data  = {$urandom, $urandom};
      if (i_ctx_valid && o_ctx_ready) begin
        ent.addr = 16'(k);
        ent.data = WW'(i_ctx_data);
        ctx_q.push_back(ent);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    i_ctx_valid = 1'b0;
    chk("ctx_beats", k, ins);
    if (!gaps) chk("ctx_cycles", cyc, ins);

    seen = 1'b0;
    for (int i = 0; i < w + 20 && !seen; i++) begin
      if (o_start) seen = 1'b1;
      else @(negedge clk);
    end
    chk("start_seen", seen, 1);
    @(negedge clk);
    chk("start_one_cycle", o_start, 0);
    chk("init_write_count", st_wr_cnt - st0, w);
    chk("init_all_written", init_q.size(), 0);
    chk("ctx_all_written", ctx_q.size(), 0);
    chk("start_pulses", start_cnt - start0, 1);

    // Play the QEA run: new state contents, and the readout they must produce
    for (int i = 0; i < w; i++) begin
      ram[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ram[i]);
    end
    i_go = 1'b1;
    i_qbit_num = 6'd2;
    @(negedge clk);
    i_go = 1'b0;
    chk("go_ignored_while_busy", o_err, 0);
    repeat (2) @(negedge clk);
    chk("wait_busy", o_busy, 1);
    chk("wait_no_output", o_out_valid, 0);
    i_complete = 1'b1;
    @(negedge clk);
    i_complete = 1'b0;

    beats = 0;
    cyc = 0;
    hold = 1'b0;
    hold_data = '0;
    while (beats < w && cyc < 20 * w + 50 && !(abort_at >= 0 && beats == abort_at)) begin
      i_out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        chk("hold_valid", o_out_valid, 1);
        chk("hold_data", o_out_data, hold_data);
      end
      if (o_out_valid && i_out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : {8{32'hbad0bad0}};
        chk("out_data", o_out_data, e);
        chk("out_last", o_out_last, (beats == w - 1));
        beats++;
      end
      hold = o_out_valid && !i_out_ready;
      hold_data = o_out_data;
      cyc++;
      @(negedge clk);
    end

    if (abort_at >= 0) begin
      chk("abort_point", beats, abort_at);
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl_zero", {o_busy, o_done, o_err, o_start, o_out_valid, o_out_last,
                              o_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea}, 0);
      chk("abort_qbit_zero", o_qbit_num, 0);
      chk("abort_addr_zero", {o_ctx_addr, o_state_addra}, 0);
      chk("abort_data_zero", o_out_data, 0);
      chk("abort_dina_zero", o_state_dina, 0);
      ctx_q.delete();
      init_q.delete();
      exp_q.delete();
      i_out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      chk("out_beats", beats, w);
      chk("out_all_seen", exp_q.size(), 0);
      chk("done_pulse", o_done, 1);
      chk("idle_after_done", o_busy, 0);
      i_out_ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", o_done, 0);
      chk("no_extra_output", o_out_valid, 0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    i_go        = 1'b0;
    i_qbit_num  = '0;
    i_ins_num   = '0;
    i_ctx_valid = 1'b0;
    i_ctx_data  = '0;
    i_out_ready = 1'b0;
    i_complete  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl_zero", {o_busy, o_done, o_err, o_start, o_out_valid, o_out_last,
                            o_ctx_ready, o_ctx_en, o_state_ena}, 0);
    chk("reset_qbit_zero", o_qbit_num, 0);
    chk("reset_out_data_zero", o_out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    reject("reject_qbit_2", 2, 10);
    reject("reject_ins_0", 11, 0);
    reject("reject_qbit_19", 19, 4);
    reject("reject_ins_65537", 11, 65537);

    run(11, 353, 1'b0, 1'b0, -1);
    run(11, 40, 1'b1, 1'b1, -1);
    run(3, 1, 1'b0, 1'b1, -1);
    run(11, 5, 1'b0, 1'b0, 100);
    run(4, 3, 1'b1, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
